// File: rtl/store_byte_serializer_pkg.sv
// Shared definitions for the store byte serializer.
//
// Holds the store size encodings used by the CPU memory stage, the FSM
// state type, and two small helpers. One helper gives the index of the
// last byte of a store. The other decides whether a request must be
// rejected because its size is invalid or its address is misaligned.
package store_byte_serializer_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_INVALID = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_DONE  = 2'b10,
    ST_ERROR = 2'b11
  } state_t;

  // Index of the final byte lane for a given size.
  // Invalid sizes never reach WRITE, so their value here does not matter.
  function automatic logic [1:0] last_index(input logic [1:0] size);
    logic [1:0] idx;
    idx = 2'd0;
    case (size)
      SZ_HALF: idx = 2'd1;
      SZ_WORD: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // A request is rejected in three cases:
  //   - its size is invalid;
  //   - it is a halfword at an odd address;
  //   - it is a word at an address that is not a multiple of four.
  function automatic logic is_bad_request(input logic [1:0] size,
                                          input logic [1:0] addr_low);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF:    bad = addr_low[0];
      SZ_WORD:    bad = (addr_low != 2'b00);
      SZ_INVALID: bad = 1'b1;
      default:    bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_byte_serializer_byte_lane_mux.sv
// Combinational byte lane selector.
//
// Ports:
//   data  - 32-bit little-endian word; lane 0 is bits 7:0
//   index - lane number, 0..3
//   lane  - the selected byte
module byte_lane_mux (
  input  logic [31:0] data,
  input  logic [1:0]  index,
  output logic [7:0]  lane
);

  // Plain 4:1 selection of one byte lane.
  always_comb begin
    lane = 8'h00;
    case (index)
      2'd0: lane = data[7:0];
      2'd1: lane = data[15:8];
      2'd2: lane = data[23:16];
      2'd3: lane = data[31:24];
      default: lane = 8'h00;
    endcase
  end

endmodule

// File: rtl/store_byte_serializer.sv
// Store byte serializer.
//
// Takes one sb/sh/sw request from the CPU memory stage. Emits it as a run
// of little-endian byte writes on a byte-wide memory port, one byte per
// accepted memory handshake. The block then pulses done, or pulses err
// when the request is rejected. A rejected request writes no bytes.
//
// Ports:
//   clk, rst   - rising-edge clock, asynchronous active-high reset
//   req_valid  - store request present
//   req_ready  - request accepted this cycle (high only when idle)
//   req_addr   - byte address of the store
//   req_wdata  - store data, lane 0 = bits 7:0
//   req_size   - 00 byte, 01 half, 10 word, 11 invalid
//   mem_we     - byte write request to memory
//   mem_addr   - byte address of the current write
//   mem_wdata  - byte being written
//   mem_ready  - memory takes the byte this cycle when mem_we is high
//   done       - one-cycle pulse: all bytes written
//   err        - one-cycle pulse: request rejected
module store_byte_serializer
  import store_byte_serializer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_size,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic                  mem_ready,
  output logic                  done,
  output logic                  err
);

  state_t                state_q, state_d;
  logic [1:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            size_q;
  logic [7:0]            lane_byte;
  logic                  last_byte;

  assign last_byte = (cnt_q == last_index(size_q));

  byte_lane_mux u_lane_mux (
    .data  (wdata_q),
    .index (cnt_q),
    .lane  (lane_byte)
  );

  // State register, request latch and byte counter.
  // The request is latched whenever it is seen in IDLE. This includes
  // requests that will be rejected; the latch is harmless then because
  // ERROR never drives the memory port. The counter advances only on an
  // accepted handshake that is not the last byte. Reaching DONE therefore
  // leaves cnt at the last index until the next request clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      size_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        cnt_q   <= 2'd0;
      end else if (state_q == ST_WRITE && mem_ready && !last_byte) begin
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  // Next-state and output decode.
  // Outputs depend only on registered state, so nothing combinational
  // runs from req_* or mem_ready to an output. The memory address and
  // data are forced to zero outside WRITE. This keeps the port quiet and
  // matches the reset values.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (is_bad_request(req_size, req_addr[1:0])) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q + {{(ADDR_WIDTH-2){1'b0}}, cnt_q};
        mem_wdata = lane_byte;
        if (mem_ready && last_byte) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_store_byte_serializer.sv
// Testbench for store_byte_serializer.
//
// The reference model works at the level of a whole request. For each
// request it works out whether the request must be rejected. Otherwise it
// works out the list of (address, byte) writes and the done pulse that
// should follow. Every cycle is then checked against that list, including
// the cycles where the memory port is stalled.
module tb_store_byte_serializer;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready;
  logic        done;
  logic        err;

  int check_count = 0;
  int pass_count  = 0;

  store_byte_serializer #(.ADDR_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .done      (done),
    .err       (err)
  );

  // 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Every output should sit at its reset value.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    checkOutput({tag, "_mem_we"},    {31'b0, mem_we},    32'd0);
    checkOutput({tag, "_mem_addr"},  mem_addr,           32'd0);
    checkOutput({tag, "_mem_wdata"}, {24'b0, mem_wdata}, 32'd0);
    checkOutput({tag, "_done"},      {31'b0, done},      32'd0);
    checkOutput({tag, "_err"},       {31'b0, err},       32'd0);
  endtask

  // Advance to just after the next rising edge, where outputs are sampled.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and checks the whole response against the model.
  // first_stall >= 0 forces the number of stall cycles on byte 0.
  // Otherwise each byte is stalled for a random 0..stall_max cycles.
  // hold_valid keeps a different request asserted while the block is busy;
  // the block must ignore it.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size, input int stall_max,
                               input int first_stall, input bit hold_valid);
    bit          exp_err;
    int          n_bytes;
    int          stall;
    logic [31:0] exp_addr;
    logic [7:0]  exp_byte;
    exp_err = (size == 2'b11) ||
              (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00);
    n_bytes = 1 << size;

    // Cycle 0: request accepted.
    checkOutput("idle_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_wdata = data;
    req_size  = size;
    nextCycle();
    if (hold_valid) begin
      req_addr  = ~addr;
      req_wdata = ~data;
      req_size  = 2'(($urandom_range(2, 0)));
    end else begin
      req_valid = 1'b0;
    end

    if (exp_err) begin
      checkOutput("err_pulse",   {31'b0, err},       32'd1);
      checkOutput("err_no_we",   {31'b0, mem_we},    32'd0);
      checkOutput("err_no_done", {31'b0, done},      32'd0);
      checkOutput("err_busy",    {31'b0, req_ready}, 32'd0);
      req_valid = 1'b0;
      nextCycle();
      checkOutput("err_ready_back", {31'b0, req_ready}, 32'd1);
      checkOutput("err_single",     {31'b0, err},       32'd0);
      checkOutput("err_idle_no_we", {31'b0, mem_we},    32'd0);
      return;
    end

    // Cycles 1..: one byte per accepted handshake, held stable while stalled.
    for (int i = 0; i < n_bytes; i++) begin
      exp_addr = addr + 32'(i);
      exp_byte = 8'(data >> (8 * i));
      if (i == 0 && first_stall >= 0) begin
        stall = first_stall;
      end else begin
        stall = int'($urandom_range(stall_max, 0));
      end
      for (int s = 0; s <= stall; s++) begin
        mem_ready = (s == stall);
        checkOutput("wr_we",    {31'b0, mem_we},    32'd1);
        checkOutput("wr_addr",  mem_addr,           exp_addr);
        checkOutput("wr_data",  {24'b0, mem_wdata}, {24'b0, exp_byte});
        checkOutput("wr_busy",  {31'b0, req_ready}, 32'd0);
        checkOutput("wr_flags", {30'b0, done, err}, 32'd0);
        nextCycle();
      end
    end

    // Completion cycle; mem_ready is irrelevant here.
    req_valid = 1'b0;
    mem_ready = 1'($urandom_range(1, 0));
    checkOutput("done_pulse",  {31'b0, done},      32'd1);
    checkOutput("done_no_we",  {31'b0, mem_we},    32'd0);
    checkOutput("done_no_err", {31'b0, err},       32'd0);
    checkOutput("done_busy",   {31'b0, req_ready}, 32'd0);
    nextCycle();
    checkOutput("ready_back",  {31'b0, req_ready}, 32'd1);
    checkOutput("done_single", {31'b0, done},      32'd0);
    checkOutput("idle_no_we",  {31'b0, mem_we},    32'd0);
    mem_ready = 1'b1;
  endtask

  // Reset behaviour, the directed cases, then randomized traffic.
  initial begin
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    req_size  = 2'b00;
    mem_ready = 1'b1;
    #2;
    checkResetOutputs("reset");
    nextCycle();
    nextCycle();
    rst = 1'b0;
    nextCycle();

    $display("[TB] directed: word, halfword with backpressure, byte");
    applyStimulus(32'h0000_0100, 32'hA1B2_C3D4, 2'b10, 0, 0, 1'b0);
    applyStimulus(32'h0000_0202, 32'h0000_BEEF, 2'b01, 0, 3, 1'b0);
    applyStimulus(32'h0000_0007, 32'h1122_3344, 2'b00, 0, 0, 1'b0);

    $display("[TB] directed: misaligned and invalid requests");
    applyStimulus(32'h0000_0102, 32'hDEAD_BEEF, 2'b10, 0, 0, 1'b0);
    applyStimulus(32'h0000_0101, 32'hDEAD_BEEF, 2'b01, 0, 0, 1'b0);
    applyStimulus(32'h0000_0000, 32'hDEAD_BEEF, 2'b11, 0, 0, 1'b0);

    $display("[TB] directed: reset in the middle of a word store");
    req_valid = 1'b1;
    req_addr  = 32'h0000_0300;
    req_wdata = 32'hCAFE_F00D;
    req_size  = 2'b10;
    mem_ready = 1'b1;
    nextCycle();
    req_valid = 1'b0;
    checkOutput("rst_mid_b0_addr", mem_addr, 32'h0000_0300);
    nextCycle();
    checkOutput("rst_mid_b1_data", {24'b0, mem_wdata}, 32'h0000_00F0);
    nextCycle();
    rst = 1'b1;
    #1;
    checkResetOutputs("rst_mid");
    nextCycle();
    checkOutput("rst_mid_held_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    nextCycle();
    checkOutput("rst_after_done", {31'b0, done}, 32'd0);
    checkOutput("rst_after_err",  {31'b0, err},  32'd0);
    applyStimulus(32'h0000_0044, 32'h5566_7788, 2'b00, 0, 0, 1'b0);

    $display("[TB] directed: address wrap with request held during WRITE");
    applyStimulus(32'hFFFF_FFFC, 32'h0102_0304, 2'b10, 0, 0, 1'b1);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 40; t++) begin
      r_addr = $urandom;
      if ($urandom_range(1, 0) == 1) begin
        r_addr[1:0] = 2'b00;
      end
      r_size = 2'($urandom_range(3, 0));
      applyStimulus(r_addr, $urandom, r_size, 2, -1,
                    1'($urandom_range(1, 0)));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/store_byte_serializer.md
Name: store_byte_serializer

Overview:
- Narrowing counterpart to the datapath's zero/sign extenders.
- Accepts one 32-bit store request (sb/sh/sw) from the CPU memory stage.
- Splits it into a sequence of 8-bit writes to a byte-wide data memory port, little-endian, one byte per accepted memory handshake.
- Reports completion with a done pulse, or a misalignment/size error with an error pulse.

Parameters:
- ADDR_WIDTH, 32, width of request and memory byte addresses.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  store request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_addr  input  ADDR_WIDTH  byte address of the store.
- req_wdata  input  32  store data; lane 0 = bits 7:0.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 invalid.
- mem_we  output  1  byte write request to memory.
- mem_addr  output  ADDR_WIDTH  byte address of the current write.
- mem_wdata  output  8  byte being written.
- mem_ready  input  1  memory accepts the byte this cycle when mem_we=1.
- done  output  1  one-cycle pulse: all bytes written.
- err  output  1  one-cycle pulse: request rejected, no bytes written.

Behaviour:
- Reset (async, rst=1): state IDLE, byte counter 0, latched address/data/size 0. Outputs: req_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0.
- States: IDLE, WRITE, DONE, ERROR.
- IDLE:
  - req_ready=1.
  - On req_valid=1: latch addr, wdata and size; clear the counter.
  - Next state is ERROR if size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]!=00. Otherwise next state is WRITE.
  - req_valid=0: stay in IDLE.
- WRITE:
  - Outputs: mem_we=1; mem_addr=latched_addr+cnt (modulo 2^ADDR_WIDTH, wraps silently); mem_wdata=latched_wdata[8*cnt+7 : 8*cnt].
  - Byte count by size: byte=1, half=2, word=4.
  - On mem_ready=1: if cnt==count-1, go to DONE; else cnt increments.
  - On mem_ready=0: hold every output stable; no change of address, data or counter.
- DONE: done=1, mem_we=0 for one cycle, then IDLE.
- ERROR: err=1, mem_we=0 for one cycle, then IDLE. Memory is never written.
- done and err are never high in the same cycle.
- req_ready=0 in WRITE, DONE and ERROR. req_valid in those states is ignored; the request is not queued.
- Latency with mem_ready tied high, measured from the acceptance cycle (cycle 0):
  - Word: bytes written in cycles 1–4, done in cycle 5, req_ready back in cycle 6.
  - Half: done in cycle 3.
  - Byte: done in cycle 2.
- Reset asserted mid-WRITE: immediate return to reset values. Partial writes already accepted are not undone; no done or err pulse is issued.
- All outputs are registered or decoded from the state register only. There is no combinational path from req_* or mem_ready to any output.

Decomposition:
- Shared package: size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10; state encoding IDLE/WRITE/DONE/ERROR.
- Sub-module byte_lane_mux: combinational select of an 8-bit lane from 32-bit data by a 2-bit index.
- The FSM and counter stay in the top.

Test Plan:
- Word store, mem_ready=1: addr=0x100, wdata=0xA1B2C3D4, size=10.
  - Expect writes (0x100,0xD4), (0x101,0xC3), (0x102,0xB2), (0x103,0xA1) in cycles 1–4.
  - done in cycle 5; err stays 0.
- Halfword store with backpressure: addr=0x202, wdata=0x0000BEEF, size=01, mem_ready low for 3 cycles then high.
  - (0x202,0xEF) held stable for 4 cycles, then (0x203,0xBE).
  - Then one done pulse.
- Byte store: addr=0x7, wdata=0x11223344, size=00.
  - Single write (0x7,0x44); done in cycle 2.
- Misaligned and invalid: word at 0x102; half at 0x101; size=11 at 0x0.
  - Each gives an err pulse the cycle after acceptance.
  - mem_we never asserted; req_ready high the following cycle.
- Reset mid-word: assert rst after the second byte is accepted.
  - Outputs go to reset values the same cycle; no done pulse.
  - A new byte store after rst is released completes normally.
- Address wrap, ADDR_WIDTH=32: word at 0xFFFFFFFC with wdata 0x01020304.
  - Addresses FFFFFFFC..FFFFFFFF, data 04,03,02,01.
  - A new req_valid held high during WRITE is ignored until req_ready returns.
